fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the core's combinational, word-addressed instruction memory (256 words; NOP 32'h00000013 beyond the loaded program).
- Owns the program counter and drives the memory address.
- Captures the returned instruction with its PC into a small FIFO, and presents {instr, pc} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing in-flight entries and restarting the PC.

---
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 95 +++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface fetch_sequencer_if;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  modport master (
    input  enable,
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fetch_count
  );

  modport slave (
    output enable,
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures {instr, pc} into a small
// FIFO and hands entries to decode over valid/ready; redirects flush and restart.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fetch_sequencer_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_OCC = CNT_W'(DEPTH);
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fcnt_q, fcnt_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];

  logic empty;
  logic pop;
  logic push;

  // A full FIFO still accepts a push when the head is popped the same cycle.
  always_comb begin
    empty  = (occ_q == '0);
    pop    = ~empty & bus.out_ready;
    push   = bus.enable & ~bus.redirect_valid & ((occ_q != FULL_OCC) | pop);

    pc_d   = pc_q;
    fcnt_d = fcnt_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    if (bus.redirect_valid) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      pc_d   = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + 32'd4;
        fcnt_d = fcnt_q + 32'd1;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q   <= RESET_PC_A;
      fcnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      fcnt_q <= fcnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      instr_mem_q[tail_q] <= bus.imem_instr;
      pc_mem_q[tail_q]    <= pc_q;
    end
  end

  // Empty outputs are muxed on occupancy so stale slot contents never leak out.
  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = ~empty;
  assign bus.out_instr   = empty ? NOP_INSTR : instr_mem_q[head_q];
  assign bus.out_pc      = empty ? 32'h0 : pc_mem_q[head_q];
  assign bus.fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic reset;
  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  logic [31:0] prog [256];
  ent_t        q [$];
  logic [31:0] mpc;
  logic [31:0] mcnt;
  int unsigned total;
  int unsigned bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a < 32'd1024) return prog[a[9:2]];
    return NOP_INSTR;
  endfunction

  always_comb bus.imem_instr = memf(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare DUT against the model mid-cycle, then advance both.
  task automatic step(input logic en, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic rst);
    ent_t e;
    reset              = rst;
    bus.enable         = en;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #4;
    chk("valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("instr", bus.out_instr, (q.size() != 0) ? q[0].instr : NOP_INSTR);
    chk("pc",    bus.out_pc,    (q.size() != 0) ? q[0].pc : 32'h0);
    chk("addr",  bus.imem_addr, mpc);
    chk("count", bus.fetch_count, mcnt);
    if (rst) begin
      q.delete();
      mpc  = RESET_PC;
      mcnt = 0;
    end else if (rv) begin
      q.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (en && q.size() < DEPTH) begin
        e.instr = memf(mpc);
        e.pc    = mpc;
        q.push_back(e);
        mpc  = mpc + 32'd4;
        mcnt = mcnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    prog[0]  = 32'h0010_0093;
    prog[1]  = 32'h0020_0113;
    prog[2]  = 32'h0020_81B3;
    prog[11] = 32'h0010_0493;

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    q.delete();
    mpc  = RESET_PC;
    mcnt = 0;

    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_instr", bus.out_instr, NOP_INSTR);
    chk("rst_pc",    bus.out_pc, 32'h0);
    chk("rst_addr",  bus.imem_addr, RESET_PC);
    chk("rst_count", bus.fetch_count, 32'h0);

    // Streaming from reset
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s1_instr", bus.out_instr, 32'h0010_0093);
    chk("s1_pc",    bus.out_pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s2_instr", bus.out_instr, 32'h0020_0113);
    chk("s2_pc",    bus.out_pc, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s3_instr", bus.out_instr, 32'h0020_81B3);
    chk("s3_pc",    bus.out_pc, 32'h8);
    chk("s3_count", bus.fetch_count, 32'd3);

    // Backpressure from reset
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_addr",  bus.imem_addr, 32'h8);
    chk("bp_instr", bus.out_instr, 32'h0010_0093);
    chk("bp_pc",    bus.out_pc, 32'h0);
    chk("bp_count", bus.fetch_count, 32'd2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_rel1", bus.out_pc, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_rel2", bus.out_pc, 32'h8);

    // Redirect while full with a concurrent pop
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h2E, 1'b0);
    chk("rd_valid", 32'(bus.out_valid), 32'h0);
    chk("rd_addr",  bus.imem_addr, 32'h2C);
    chk("rd_count", bus.fetch_count, 32'd2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd_pc",    bus.out_pc, 32'h2C);
    chk("rd_instr", bus.out_instr, 32'h0010_0493);

    // enable low drains the FIFO and holds the PC
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("en_valid", 32'(bus.out_valid), 32'h0);
    chk("en_instr", bus.out_instr, NOP_INSTR);
    chk("en_addr",  bus.imem_addr, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("en_resume", bus.out_pc, 32'h8);

    // PC wrap
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wr_pc0", bus.out_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wr_pc1", bus.out_pc, 32'h0);

    // Reset mid-stream with two entries queued
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("mr_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_addr",  bus.imem_addr, RESET_PC);
    chk("mr_count", bus.fetch_count, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        en, rdy, rv, rst;
      logic [31:0] rpc;
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      rv  = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom_range(0, 1100);
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      step(en, rdy, rv, rpc, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
